// File: rtl/multi_port_queueing_domain_if.sv
// Packet queueing domain bus: packetizer inputs, scheduler pop port,
// popped packet output, queue status and kill thresholds.
interface multi_port_queueing_domain_if #(
    parameter int NUMBER_OF_INPUTS = 2,
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int DATA_SIZE        = 678,
    parameter int QUEUE_LENGTH     = 16,
    parameter int REGISTER_SIZE    = 32
) ();
    localparam int QW = $clog2(NUMBER_OF_QUEUES);
    localparam int OW = $clog2(QUEUE_LENGTH + 1);

    logic [NUMBER_OF_INPUTS*DATA_SIZE-1:0]     in_packet;
    logic [NUMBER_OF_INPUTS-1:0]               in_valid;
    logic [NUMBER_OF_INPUTS*QW-1:0]            in_id;
    logic [NUMBER_OF_INPUTS-1:0]               in_ready;
    logic [QW-1:0]                             scheduler_id;
    logic                                      scheduler_pop;
    logic                                      out_valid;
    logic [DATA_SIZE-1:0]                      out_packet;
    logic [NUMBER_OF_QUEUES-1:0]               empty;
    logic [NUMBER_OF_QUEUES-1:0]               full;
    logic [NUMBER_OF_QUEUES*OW-1:0]            occupancy;
    logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0] high_threshold;
    logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0] low_threshold;
    logic [NUMBER_OF_QUEUES-1:0]               kill_the_core;

    modport master (
        output in_packet, in_valid, in_id,
        output scheduler_id, scheduler_pop,
        output high_threshold, low_threshold,
        input  in_ready, out_valid, out_packet,
        input  empty, full, occupancy, kill_the_core
    );

    modport slave (
        input  in_packet, in_valid, in_id,
        input  scheduler_id, scheduler_pop,
        input  high_threshold, low_threshold,
        output in_ready, out_valid, out_packet,
        output empty, full, occupancy, kill_the_core
    );
endinterface

// File: rtl/multi_port_queueing_domain.sv
// Round-robin merge of packetizer streams into per-core FIFOs, with a
// registered scheduler pop stage and per-queue kill hysteresis.
module multi_port_queueing_domain #(
    parameter int NUMBER_OF_INPUTS = 2,
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int DATA_SIZE        = 678,
    parameter int QUEUE_LENGTH     = 16,
    parameter int REGISTER_SIZE    = 32
) (
    input logic clock,
    input logic reset,
    multi_port_queueing_domain_if.slave bus
);
    localparam int NI = NUMBER_OF_INPUTS;
    localparam int NQ = NUMBER_OF_QUEUES;
    localparam int DS = DATA_SIZE;
    localparam int RS = REGISTER_SIZE;
    localparam int QW = $clog2(NQ);
    localparam int OW = $clog2(QUEUE_LENGTH + 1);
    localparam int PW = $clog2(QUEUE_LENGTH);
    localparam int IW = (NI > 1) ? $clog2(NI) : 1;

    localparam logic [QW:0]   NQ_LIM = NQ[QW:0];
    localparam logic [OW-1:0] QL_LIM = QUEUE_LENGTH[OW-1:0];
    localparam logic [IW-1:0] LAST_IN = IW'(NI - 1);

    logic [QW-1:0] in_id_a  [NI];
    logic [DS-1:0] in_pkt_a [NI];
    logic [NI-1:0] eligible;

    logic [IW-1:0] rr;
    logic [IW-1:0] rr_next;
    logic          grant_any;
    logic [IW-1:0] grant_idx;
    logic [NI-1:0] grant_vec;
    int            scan_idx;

    logic          push;
    logic [QW-1:0] push_q;
    logic [DS-1:0] push_data;
    logic          pop_ok;
    logic [QW-1:0] pop_q;

    wire [NQ-1:0]  empty_q;
    wire [NQ-1:0]  full_q;
    wire [NQ-1:0]  kill_w;
    wire [OW-1:0]  occ_w     [NQ];
    wire [DS-1:0]  head_data [NQ];

    // Unpack the flat input buses and work out which inputs may push.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            in_id_a[i]  = bus.in_id[i*QW +: QW];
            in_pkt_a[i] = bus.in_packet[i*DS +: DS];
            eligible[i] = bus.in_valid[i]
                       && ({1'b0, in_id_a[i]} < NQ_LIM)
                       && !full_q[in_id_a[i]];
        end
    end

    // First eligible input starting at the round-robin pointer wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int k = 0; k < NI; k++) begin
            scan_idx = int'(rr) + k;
            if (scan_idx >= NI) scan_idx = scan_idx - NI;
            if (!grant_any && eligible[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = IW'(scan_idx);
            end
        end
    end

    // One-hot ready, write request and next pointer from the grant.
    always_comb begin
        grant_vec = '0;
        if (grant_any) grant_vec[grant_idx] = 1'b1;
        push      = grant_any;
        push_q    = in_id_a[grant_idx];
        push_data = in_pkt_a[grant_idx];
        rr_next   = (grant_idx == LAST_IN) ? '0 : grant_idx + 1'b1;
    end

    assign bus.in_ready = grant_vec;

    // Pops are judged on registered state only: no push-to-pop bypass.
    always_comb begin
        pop_q  = bus.scheduler_id;
        pop_ok = bus.scheduler_pop
              && ({1'b0, pop_q} < NQ_LIM)
              && !empty_q[pop_q];
    end

    // Round-robin pointer moves past the winner only on a grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr <= '0;
        end else if (grant_any) begin
            rr <= rr_next;
        end
    end

    for (genvar q = 0; q < NQ; q++) begin : g_queue
        logic [DS-1:0] mem [QUEUE_LENGTH];
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [OW-1:0] cnt;
        logic          kill_r;
        logic          push_here;
        logic          pop_here;
        logic [RS-1:0] occ_ext;
        logic [RS-1:0] hi_th;
        logic [RS-1:0] lo_th;

        assign push_here = push && (push_q == QW'(q));
        assign pop_here  = pop_ok && (pop_q == QW'(q));
        assign occ_ext   = RS'(cnt);
        assign hi_th     = bus.high_threshold[q*RS +: RS];
        assign lo_th     = bus.low_threshold[q*RS +: RS];

        // Packet storage is left uninitialised across reset.
        always_ff @(posedge clock) begin
            if (push_here) mem[wr_ptr] <= push_data;
        end

        // Pointers wrap naturally; the counter tracks fill level.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push_here) wr_ptr <= wr_ptr + 1'b1;
                if (pop_here)  rd_ptr <= rd_ptr + 1'b1;
                if (push_here && !pop_here)
                    cnt <= cnt + 1'b1;
                else if (!push_here && pop_here)
                    cnt <= cnt - 1'b1;
            end
        end

        // Kill hysteresis: zero high disables, set beats clear.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                kill_r <= 1'b0;
            end else if (hi_th == '0) begin
                kill_r <= 1'b0;
            end else if (occ_ext >= hi_th) begin
                kill_r <= 1'b1;
            end else if (occ_ext <= lo_th) begin
                kill_r <= 1'b0;
            end
        end

        assign empty_q[q]   = (cnt == '0);
        assign full_q[q]    = (cnt == QL_LIM);
        assign kill_w[q]    = kill_r;
        assign occ_w[q]     = cnt;
        assign head_data[q] = mem[rd_ptr];
    end

    // Pack per-queue status onto the flat output buses.
    always_comb begin
        bus.occupancy = '0;
        for (int q = 0; q < NQ; q++) begin
            bus.occupancy[q*OW +: OW] = occ_w[q];
        end
    end

    assign bus.empty         = empty_q;
    assign bus.full          = full_q;
    assign bus.kill_the_core = kill_w;

    // Registered output stage: pulse valid, hold last packet.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.out_valid  <= 1'b0;
            bus.out_packet <= '0;
        end else begin
            bus.out_valid <= pop_ok;
            if (pop_ok) bus.out_packet <= head_data[pop_q];
        end
    end
endmodule

// File: tb/tb_multi_port_queueing_domain.sv
// Directed bench for multi_port_queueing_domain: arbitration, FIFO
// order, simultaneous push/pop, kill hysteresis and async reset.
module tb_multi_port_queueing_domain;
    localparam int NI = 2;
    localparam int NQ = 4;
    localparam int DS = 678;
    localparam int QL = 16;
    localparam int RS = 32;
    localparam int QW = 2;
    localparam int OW = 5;

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    multi_port_queueing_domain_if #(
        .NUMBER_OF_INPUTS(NI), .NUMBER_OF_QUEUES(NQ),
        .DATA_SIZE(DS), .QUEUE_LENGTH(QL), .REGISTER_SIZE(RS)
    ) bus ();

    multi_port_queueing_domain #(
        .NUMBER_OF_INPUTS(NI), .NUMBER_OF_QUEUES(NQ),
        .DATA_SIZE(DS), .QUEUE_LENGTH(QL), .REGISTER_SIZE(RS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    task automatic check(input string tag,
                         input logic [767:0] obs,
                         input logic [767:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DS-1:0] mk(input int tag);
        logic [DS-1:0] v;
        v = '0;
        v[31:0]      = 32'(tag);
        v[400 +: 16] = 16'(tag * 3 + 1);
        v[DS-1 -: 32] = ~32'(tag);
        return v;
    endfunction

    function automatic logic [OW-1:0] occ(input int q);
        return bus.occupancy[q*OW +: OW];
    endfunction

    task automatic push(input int inp, input int q, input int tag);
        @(negedge clock);
        bus.in_valid = '0;
        bus.in_valid[inp] = 1'b1;
        bus.in_id[inp*QW +: QW] = QW'(q);
        bus.in_packet[inp*DS +: DS] = mk(tag);
        @(negedge clock);
        bus.in_valid = '0;
    endtask

    task automatic pop(input int q);
        @(negedge clock);
        bus.scheduler_id  = QW'(q);
        bus.scheduler_pop = 1'b1;
        @(negedge clock);
        bus.scheduler_pop = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.in_packet = '0;
        bus.in_valid = '0;
        bus.in_id = '0;
        bus.scheduler_id = '0;
        bus.scheduler_pop = 1'b0;
        bus.high_threshold = '0;
        bus.low_threshold = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_occ", bus.occupancy, 0);
        check("rst_empty", bus.empty, 4'hF);
        check("rst_full", bus.full, 0);
        check("rst_kill", bus.kill_the_core, 0);
        check("rst_oval", bus.out_valid, 0);
        check("rst_opkt", bus.out_packet, 0);
        check("rst_rdy", bus.in_ready, 0);

        // Fairness: input 0 -> queue 0, input 1 -> queue 1.
        @(negedge clock);
        bus.high_threshold[31:0] = 32'd8;
        bus.low_threshold[31:0]  = 32'd3;
        bus.in_id = {2'd1, 2'd0};
        bus.in_packet = {mk(2000), mk(1000)};
        bus.in_valid = 2'b11;
        for (int c = 0; c < 32; c++) begin
            #1;
            check("rr_grant", bus.in_ready,
                  (c % 2 == 0) ? 2'b01 : 2'b10);
            @(negedge clock);
        end
        check("rr_occ0", occ(0), 16);
        check("rr_occ1", occ(1), 16);
        check("rr_full", bus.full, 4'b0011);
        #1;
        check("rr_rdy_idle", bus.in_ready, 0);
        @(negedge clock);
        check("rr_rdy_idle2", bus.in_ready, 0);
        check("rr_kill0", bus.kill_the_core, 4'b0001);

        // Blocked input 0 must not stall input 1.
        bus.in_id = {2'd3, 2'd1};
        for (int c = 0; c < 5; c++) begin
            #1;
            check("blk_grant", bus.in_ready, 2'b10);
            @(negedge clock);
        end
        bus.in_valid = '0;
        check("blk_occ3", occ(3), 5);
        pop(2);
        check("pop_empty_q", bus.out_valid, 0);

        // Async reset with a pop in flight.
        @(negedge clock);
        bus.scheduler_id = 2'd0;
        bus.scheduler_pop = 1'b1;
        @(posedge clock);
        #2;
        bus.scheduler_pop = 1'b0;
        check("mid_oval", bus.out_valid, 1);
        reset = 1'b1;
        #1;
        check("ar_oval", bus.out_valid, 0);
        check("ar_kill", bus.kill_the_core, 0);
        check("ar_occ", bus.occupancy, 0);
        check("ar_empty", bus.empty, 4'hF);
        @(negedge clock);
        reset = 1'b0;
        bus.high_threshold = '0;
        bus.low_threshold = '0;
        push(0, 2, 7777);
        push(1, 2, 7778);
        pop(2);
        check("post_rst_first", {bus.out_valid, bus.out_packet},
              {1'b1, mk(7777)});
        pop(2);
        check("post_rst_second", {bus.out_valid, bus.out_packet},
              {1'b1, mk(7778)});
        check("post_rst_empty", bus.empty[2], 1);

        // Fill queue 2, drain back-to-back, then wrap.
        for (int k = 0; k < 16; k++) push(k % 2, 2, 100 + k);
        check("fill_full2", bus.full[2], 1);
        @(negedge clock);
        bus.scheduler_id = 2'd2;
        bus.scheduler_pop = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            check("drain", {bus.out_valid, bus.out_packet},
                  {1'b1, mk(100 + k)});
            if (k == 15) bus.scheduler_pop = 1'b0;
        end
        for (int k = 0; k < 20; k++) begin
            push(0, 2, 500 + k);
            pop(2);
            check("wrap", {bus.out_valid, bus.out_packet},
                  {1'b1, mk(500 + k)});
        end
        check("wrap_empty2", bus.empty[2], 1);

        // Simultaneous push and pop at occupancy 5.
        for (int k = 0; k < 5; k++) push(0, 0, 300 + k);
        @(negedge clock);
        bus.in_valid = 2'b01;
        bus.in_id = {2'd0, 2'd0};
        bus.in_packet[DS-1:0] = mk(305);
        bus.scheduler_id = 2'd0;
        bus.scheduler_pop = 1'b1;
        @(negedge clock);
        bus.in_valid = '0;
        bus.scheduler_pop = 1'b0;
        check("pp_occ5", occ(0), 5);
        check("pp_out", {bus.out_valid, bus.out_packet},
              {1'b1, mk(300)});

        // Full queue: push rejected, pop proceeds.
        for (int k = 6; k < 17; k++) push(0, 0, 300 + k);
        check("pp_full0", bus.full[0], 1);
        @(negedge clock);
        bus.in_valid = 2'b01;
        bus.in_id = {2'd0, 2'd0};
        bus.in_packet[DS-1:0] = mk(999);
        bus.scheduler_id = 2'd0;
        bus.scheduler_pop = 1'b1;
        #1;
        check("pp_full_rdy", bus.in_ready, 0);
        @(negedge clock);
        bus.in_valid = '0;
        bus.scheduler_pop = 1'b0;
        check("pp_occ15", occ(0), 15);
        check("pp_full_out", bus.out_packet, mk(301));

        // Empty queue: pop rejected, push lands.
        @(negedge clock);
        bus.in_valid = 2'b01;
        bus.in_id = {2'd0, 2'd3};
        bus.in_packet[DS-1:0] = mk(888);
        bus.scheduler_id = 2'd3;
        bus.scheduler_pop = 1'b1;
        @(negedge clock);
        bus.in_valid = '0;
        bus.scheduler_pop = 1'b0;
        check("pe_oval", bus.out_valid, 0);
        check("pe_occ3", occ(3), 1);

        // Kill hysteresis on queue 1: high 8, low 3.
        bus.high_threshold[63:32] = 32'd8;
        bus.low_threshold[63:32]  = 32'd3;
        for (int k = 0; k < 8; k++) push(1, 1, 600 + k);
        check("kill_not_yet", bus.kill_the_core[1], 0);
        @(negedge clock);
        check("kill_set", bus.kill_the_core[1], 1);
        for (int k = 0; k < 4; k++) pop(1);
        @(negedge clock);
        check("kill_hold4", bus.kill_the_core[1], 1);
        check("kill_occ4", occ(1), 4);
        pop(1);
        @(negedge clock);
        check("kill_clear3", bus.kill_the_core[1], 0);
        for (int k = 0; k < 5; k++) push(1, 1, 700 + k);
        @(negedge clock);
        check("kill_reset8", bus.kill_the_core[1], 1);
        bus.high_threshold[63:32] = 32'd0;
        @(negedge clock);
        check("kill_disable", bus.kill_the_core, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_port_queueing_domain.md
# multi_port_queueing_domain

Parametrised successor of the packet dispatch/queueing stage between the packetizers and the serializer. It merges NUMBER_OF_INPUTS decoupled packet streams into NUMBER_OF_QUEUES per-core FIFOs, using fair round-robin input arbitration. It pops the queue selected by the scheduler into a registered output stage, and drives a per-queue kill_the_core vector with high/low hysteresis thresholds. The block replaces the fixed two-input, four-kill-line arrangement.

## Interface
Parameters:
- NUMBER_OF_INPUTS, 2: packetizer ports, ≥1.
- NUMBER_OF_QUEUES, 4: per-core queues, ≥2.
- DATA_SIZE, 678: packet width in bits.
- QUEUE_LENGTH, 16: entries per queue; power of two, ≥2.
- REGISTER_SIZE, 32: threshold register width.

Ports (QW = $clog2(NUMBER_OF_QUEUES), OW = $clog2(QUEUE_LENGTH+1)):
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- in_packet  in  NUMBER_OF_INPUTS×DATA_SIZE  packet per input.
- in_valid  in  NUMBER_OF_INPUTS  packet valid per input.
- in_id  in  NUMBER_OF_INPUTS×QW  target queue per input.
- in_ready  out  NUMBER_OF_INPUTS  one-hot-or-zero grant.
- scheduler_id  in  QW  queue to pop.
- scheduler_pop  in  1  pop request (scheduler valid_and_ready).
- out_valid  out  1  output packet valid, one-cycle pulse.
- out_packet  out  DATA_SIZE  popped packet.
- empty  out  NUMBER_OF_QUEUES  queue empty.
- full  out  NUMBER_OF_QUEUES  queue full.
- occupancy  out  NUMBER_OF_QUEUES×OW  entries held per queue.
- high_threshold  in  NUMBER_OF_QUEUES×REGISTER_SIZE  kill set level; 0 disables.
- low_threshold  in  NUMBER_OF_QUEUES×REGISTER_SIZE  kill clear level.
- kill_the_core  out  NUMBER_OF_QUEUES  per-core throttle request.

## Operation
- Reset values:
  - occupancy = 0, empty = all 1, full = 0.
  - kill_the_core = 0, out_valid = 0, out_packet = 0.
  - Read/write pointers = 0, round-robin pointer rr = 0.
  - FIFO storage is not cleared. Reset mid-operation discards all queued packets and any pending output.
- Input arbitration: at most one push per cycle.
  - An input i is eligible when in_valid[i]=1, in_id[i] < NUMBER_OF_QUEUES, and full[in_id[i]]=0.
  - Grant g = first eligible index scanning rr, rr+1, … modulo NUMBER_OF_INPUTS. in_ready[g]=1; all other in_ready bits are 0.
  - On a grant, the packet is written at the tail of queue in_id[g], and rr ← (g+1) mod NUMBER_OF_INPUTS. With no grant, rr is unchanged.
  - An input targeting a full or out-of-range queue never blocks other inputs.
- Pop: accepted when scheduler_pop=1, scheduler_id < NUMBER_OF_QUEUES, and empty[scheduler_id]=0.
  - On accept: the head entry is registered into out_packet, out_valid=1 the next cycle, and the read pointer advances.
  - A request that is not accepted gives out_valid=0 next cycle. out_packet holds its last value.
  - There is no output back-pressure; the scheduler only pops when the serializer is ready.
- Simultaneous push and pop on the same queue:
  - Both occur and occupancy is unchanged.
  - full/empty are evaluated on registered state, so a full queue rejects a push even when popped in the same cycle.
  - An empty queue rejects the pop even when pushed in the same cycle (no bypass).
- Pointers are log2(QUEUE_LENGTH) bits wide and wrap naturally. Occupancy is a separate OW-bit counter; full = (occupancy == QUEUE_LENGTH).
- Kill hysteresis, per queue q, registered. Occupancy is zero-extended to REGISTER_SIZE:
  - If high_threshold[q]=0: kill ← 0.
  - Else if occupancy ≥ high_threshold[q]: kill ← 1 (set has priority).
  - Else if occupancy ≤ low_threshold[q]: kill ← 0.
  - Otherwise kill holds its value.
  - A high_threshold above QUEUE_LENGTH never sets kill.

## Timing
- in_ready is combinational from in_valid, in_id, full and rr. There is no combinational path from in_ready back into the grant.
- Push at edge t: occupancy, empty and full update at t+1. kill_the_core reflects it at t+2.
- Pop request at cycle t: out_valid/out_packet valid during cycle t+1. Sustained throughput is one pop per cycle.
- Full throughput is one push and one pop per cycle, to any queues.
- Asserting reset forces outputs to reset values immediately (asynchronous). The first push can be accepted on the first edge after deassertion.

## Test plan
- Round-robin fairness:
  - Stimulus: NUMBER_OF_INPUTS=2, both inputs continuously valid to queue 0 and queue 1, no pops.
  - Required: grants alternate 0,1,0,1… and each queue reaches occupancy 16 with full=1. After that, in_ready stays 0.
- Fill/drain with wrap:
  - Stimulus: push 16 distinct packets to queue 2, pop 16 with scheduler_id=2, then repeat 20 push/pop pairs.
  - Required: FIFO order is preserved across pointer wrap, out_valid rises one cycle after each pop, and empty=1 at the end.
- Simultaneous push and pop:
  - Stimulus 1: queue at occupancy 5, push and pop in the same cycle. Required: occupancy stays 5.
  - Stimulus 2: queue full, push and pop in the same cycle. Required: push rejected, occupancy becomes 15.
  - Stimulus 3: queue empty, push and pop in the same cycle. Required: out_valid=0, occupancy becomes 1.
- Kill hysteresis:
  - Stimulus: high=8, low=3. Fill to 8, drain to 4, then to 3.
  - Required: kill rises 2 cycles after the 8th push, holds at 4, and clears at 3. Setting high=0 clears kill within 1 cycle.
- Blocked input isolation:
  - Stimulus: input 0 targets full queue 1, input 1 targets empty queue 3.
  - Required: input 1 is granted every cycle and in_ready[0] stays 0. An out-of-range scheduler_id pop yields out_valid=0.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously between edges with queues partially filled and a pop in flight.
  - Required: out_valid, kill_the_core and occupancy read 0 and empty reads all 1 immediately. After release, the first popped packet is the first one pushed post-reset.
